// File: rtl/controller_sequencer_pkg.sv
// Shared constants and the control-word decoder for the SAP-style sequencer.
// Ports: none (package). Provides opcodes, one-hot T-state enum, control-word bit indices.
// Optional macro CTRL_EXT_OPS_EN adds the STA and JMP opcodes to the decoder.
package sap_ctrl_pkg;

    localparam int OP_W  = 4;
    localparam int T_NUM = 6;

    localparam logic [OP_W-1:0] OP_LDA = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_W-1:0] OP_STA = 4'h4;
    localparam logic [OP_W-1:0] OP_JMP = 4'h6;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [T_NUM-1:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    // Control word bits are stored active-high ("strobe asserted"); the top
    // converts to pin polarity.
    localparam int CW_CP = 0;
    localparam int CW_EP = 1;
    localparam int CW_LM = 2;
    localparam int CW_CE = 3;
    localparam int CW_LI = 4;
    localparam int CW_EI = 5;
    localparam int CW_LA = 6;
    localparam int CW_EA = 7;
    localparam int CW_SU = 8;
    localparam int CW_EU = 9;
    localparam int CW_LB = 10;
    localparam int CW_LO = 11;
    localparam int CW_LP = 12;
    localparam int CW_WE = 13;
    localparam int CW_W  = 14;

    // Pure decode of T-state and opcode; halt and reset gating happen in the top.
    function automatic logic [CW_W-1:0] decode_cw(input t_state_e t, input logic [OP_W-1:0] op);
        logic [CW_W-1:0] cw;
        cw = '0;
        case (t)
            T1: begin cw[CW_EP] = 1'b1; cw[CW_LM] = 1'b1; end
            T2: cw[CW_CP] = 1'b1;
            T3: begin cw[CW_CE] = 1'b1; cw[CW_LI] = 1'b1; end
            T4: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB: begin cw[CW_EI] = 1'b1; cw[CW_LM] = 1'b1; end
                    OP_OUT: begin cw[CW_EA] = 1'b1; cw[CW_LO] = 1'b1; end
`ifdef CTRL_EXT_OPS_EN
                    OP_STA: begin cw[CW_EI] = 1'b1; cw[CW_LM] = 1'b1; end
                    OP_JMP: begin cw[CW_EI] = 1'b1; cw[CW_LP] = 1'b1; end
`endif
                    default: cw = '0;
                endcase
            end
            T5: begin
                case (op)
                    OP_LDA: begin cw[CW_CE] = 1'b1; cw[CW_LA] = 1'b1; end
                    OP_ADD: begin cw[CW_CE] = 1'b1; cw[CW_LB] = 1'b1; end
                    OP_SUB: begin cw[CW_CE] = 1'b1; cw[CW_LB] = 1'b1; cw[CW_SU] = 1'b1; end
`ifdef CTRL_EXT_OPS_EN
                    OP_STA: begin cw[CW_EA] = 1'b1; cw[CW_WE] = 1'b1; end
`endif
                    default: cw = '0;
                endcase
            end
            T6: begin
                case (op)
                    OP_ADD: begin cw[CW_EU] = 1'b1; cw[CW_LA] = 1'b1; end
                    OP_SUB: begin cw[CW_EU] = 1'b1; cw[CW_LA] = 1'b1; cw[CW_SU] = 1'b1; end
                    default: cw = '0;
                endcase
            end
            default: cw = '0;
        endcase
        return cw;
    endfunction

endpackage

// File: rtl/controller_sequencer_if.sv
// Bundle of the sequencer's opcode input, control strobes and status.
// Ports: op_code in; cp/ep/su/ea/eu active-high, *_n active-low strobes; t_state, hlt status.
// master = sequencer side, slave = datapath/observer side.
interface controller_sequencer_if;
    import sap_ctrl_pkg::*;

    logic [OP_W-1:0]  op_code;
    logic             cp;
    logic             ep;
    logic             lm_n;
    logic             ce_n;
    logic             li_n;
    logic             ei_n;
    logic             la_n;
    logic             ea;
    logic             su;
    logic             eu;
    logic             lb_n;
    logic             lo_n;
    logic             lp_n;
    logic             we_n;
    logic [T_NUM-1:0] t_state;
    logic             hlt;

    modport master (
        input  op_code,
        output cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, lp_n, we_n,
        output t_state, hlt
    );

    modport slave (
        output op_code,
        input  cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, lp_n, we_n,
        input  t_state, hlt
    );

endinterface

// File: rtl/controller_sequencer_ring_counter.sv
// Six-state one-hot ring counter T1..T6 with hold.
// Ports: clk, clr_n (sync active-low -> T1), hold (freeze current state), t_state one-hot out.
// Latency: advances one state per clock unless hold is high.
module ring_counter
    import sap_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             clr_n,
    input  logic             hold,
    output logic [T_NUM-1:0] t_state
);

    t_state_e t_state_q;
    t_state_e t_state_d;

    always_comb begin
        t_state_d = t_state_q;
        if (!hold) begin
            case (t_state_q)
                T1:      t_state_d = T2;
                T2:      t_state_d = T3;
                T3:      t_state_d = T4;
                T4:      t_state_d = T5;
                T5:      t_state_d = T6;
                T6:      t_state_d = T1;
                default: t_state_d = T1; // recover from any non-one-hot value
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            t_state_q <= T1;
        end else begin
            t_state_q <= t_state_d;
        end
    end

    assign t_state = t_state_q;

endmodule

// File: rtl/controller_sequencer.sv
// Control sequencer: decodes op_code against a one-hot T-state ring into load/enable strobes.
// Ports: clk, clr_n (sync active-low), bus (controller_sequencer_if.master: op_code in, strobes/t_state/hlt out).
// Strobes are combinational from t_state/op_code; HLT at T4 freezes the ring until clr_n. Macro: CTRL_EXT_OPS_EN.
module controller_sequencer
    import sap_ctrl_pkg::*;
(
    input  logic                        clk,
    input  logic                        clr_n,
    controller_sequencer_if.master      bus
);

    logic [T_NUM-1:0] t_state;
    logic             hlt_dec;
    logic             halted_q;
    logic             halted_d;
    logic             hold;
    logic [CW_W-1:0]  cw;

    ring_counter u_ring (
        .clk     (clk),
        .clr_n   (clr_n),
        .hold    (hold),
        .t_state (t_state)
    );

    // HLT is recognised in T4 the same cycle it is seen, so hlt and the
    // freeze take effect before the halted flag is even registered.
    assign hlt_dec = (t_state == T4) && (bus.op_code == OP_HLT);

    always_comb begin
        halted_d = halted_q | hlt_dec;
        hold     = halted_d;
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    // Halted cycles ignore op_code entirely, and clr_n low kills every strobe.
    always_comb begin
        cw = decode_cw(t_state_e'(t_state), bus.op_code);
        if (!clr_n || halted_d) begin
            cw = '0;
        end
    end

    assign bus.cp   =  cw[CW_CP];
    assign bus.ep   =  cw[CW_EP];
    assign bus.lm_n = ~cw[CW_LM];
    assign bus.ce_n = ~cw[CW_CE];
    assign bus.li_n = ~cw[CW_LI];
    assign bus.ei_n = ~cw[CW_EI];
    assign bus.la_n = ~cw[CW_LA];
    assign bus.ea   =  cw[CW_EA];
    assign bus.su   =  cw[CW_SU];
    assign bus.eu   =  cw[CW_EU];
    assign bus.lb_n = ~cw[CW_LB];
    assign bus.lo_n = ~cw[CW_LO];

`ifdef CTRL_EXT_OPS_EN
    assign bus.lp_n = ~cw[CW_LP];
    assign bus.we_n = ~cw[CW_WE];
`else
    // Extension strobes never assert in this build; the decoder leaves their bits clear.
    logic unused_ext_bits;
    assign unused_ext_bits = cw[CW_LP] | cw[CW_WE];
    assign bus.lp_n = 1'b1;
    assign bus.we_n = 1'b1;
`endif

    assign bus.t_state = t_state;
    assign bus.hlt     = clr_n & halted_d;

endmodule

// File: doc/controller_sequencer.md
Name: controller_sequencer

Overview:
- Control unit that consumes the instruction register's 4-bit op_code and drives every load/enable strobe on the 8-bit W-bus machine.
- A 6-state one-hot ring counter (T1..T6) sequences fetch (T1-T3) and execute (T4-T6).
- Outputs are the per-T-state control word for PC, MAR, RAM, IR, accumulator, ALU, B register and output register.

Parameters:
- OP_W, 4, op_code width; fixed to the instruction register's upper nibble.
- T_NUM, 6, number of ring states; the only legal value is 6.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- clr_n  in  1  synchronous active-low reset
- op_code  in  4  opcode from instruction register (ir[7:4])
- cp  out  1  PC increment
- ep  out  1  PC drives W-bus
- lm_n  out  1  MAR load, active-low
- ce_n  out  1  RAM drives W-bus, active-low
- li_n  out  1  IR load, active-low
- ei_n  out  1  IR address nibble drives W-bus, active-low
- la_n  out  1  accumulator load, active-low
- ea  out  1  accumulator drives W-bus
- su  out  1  ALU subtract select
- eu  out  1  ALU drives W-bus
- lb_n  out  1  B register load, active-low
- lo_n  out  1  output register load, active-low
- lp_n  out  1  PC load from W-bus, active-low (extension)
- we_n  out  1  RAM write, active-low (extension)
- t_state  out  6  one-hot ring state, bit0 = T1
- hlt  out  1  processor halted

Behaviour:
- Reset: clr_n low at a rising edge sets t_state to 6'b000001 (T1) and clears the halted flag.
- While clr_n is low, all strobes are combinationally forced inactive: active-high = 0, active-low = 1, hlt = 0.
- Ring: T1 -> T2 -> ... -> T6 -> T1, one state per clock. Exactly one t_state bit is high at all times.
- Control word is combinational from t_state and op_code. Unlisted strobes are inactive.
- T1: ep=1, lm_n=0.
- T2: cp=1.
- T3: ce_n=0, li_n=0. op_code is valid from T4 onward.
- LDA 4'h0: T4 ei_n=0, lm_n=0. T5 ce_n=0, la_n=0. T6 idle.
- ADD 4'h1: T4 ei_n=0, lm_n=0. T5 ce_n=0, lb_n=0. T6 eu=1, la_n=0.
- SUB 4'h2: same as ADD, plus su=1 in T5 and T6.
- OUT 4'hE: T4 ea=1, lo_n=0. T5-T6 idle.
- HLT 4'hF: at T4, state holds at T4 and the halted flag sets. hlt=1 from that cycle onward.
- HLT strobes: all inactive. Only clr_n releases the halt.
- Other opcodes: NOP; T4-T6 all inactive, ring continues.
- op_code changes during T1-T3 do not affect the fetch strobes.
- Reset during any state, including halted, returns to T1 at the next edge.

Optional Feature:
- Macro: CTRL_EXT_OPS_EN.
- Defined:
  - STA 4'h4: T4 ei_n=0, lm_n=0. T5 ea=1, we_n=0. T6 idle.
  - JMP 4'h6: T4 ei_n=0, lp_n=0. T5-T6 idle.
- Undefined: 4'h4 and 4'h6 decode as NOP. lp_n and we_n are tied to 1. Ports remain present.

Decomposition:
- Package sap_ctrl_pkg:
  - opcode constants (OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_JMP, OP_OUT, OP_HLT)
  - one-hot T-state constants
  - control-word bit-index constants
- Sub-module ring_counter: clk, clr_n, hold input, 6-bit one-hot output.
  - Hold is driven by the HLT decode.

Test Plan:
- Reset, then 6 clocks with op_code=4'h0 -> t_state sequence 01,02,04,08,10,20,01. T1 ep=1/lm_n=0, T2 cp=1, T3 ce_n=0/li_n=0, T4 ei_n=0/lm_n=0, T5 ce_n=0/la_n=0.
- op_code=4'h2 -> T5 lb_n=0/ce_n=0/su=1; T6 eu=1/la_n=0/su=1.
- op_code=4'hF -> enters T4, hlt=1, t_state stays 08 for 20 clocks with all strobes inactive. clr_n low one edge -> t_state=01, hlt=0.
- clr_n asserted in T5 of ADD -> strobes immediately inactive; next edge t_state=01.
- op_code=4'h6 with CTRL_EXT_OPS_EN -> T4 ei_n=0/lp_n=0. Without the macro -> T4-T6 all inactive, lp_n=1.
- op_code=4'hE -> T4 ea=1/lo_n=0. op_code=4'h9 -> T4-T6 all inactive, ring wraps to T1.
